// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline, including the shared-memory port arbiter with a timeout watchdog.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             mem_sel,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DATA  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tcnt;
    logic       luse;
    logic       tmo_hit;
    logic       data_done;
    logic       err_pulse;

    assign luse      = ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign tmo_hit   = (tcnt == 8'(TIMEOUT - 1));
    assign data_done = (state == S_DATA) && (mem_ready || tmo_hit);
    // A watchdog expiry only counts as an error if memory did not answer in the same cycle.
    assign err_pulse = (state == S_DATA) && !mem_ready && tmo_hit;
    assign mem_sel   = (state == S_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            tcnt       <= 8'd0;
            mem_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_FETCH) && mem_req)
                tcnt <= 8'd0;
            else if (state == S_DATA)
                tcnt <= tcnt + 8'd1;
            mem_err    <= err_pulse;
            err_sticky <= err_sticky | err_pulse;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_en        = 1'b1;
        pc_sel       = 1'b0;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        if (rst) begin
            state_nxt = S_FETCH;
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (((state == S_FETCH) && mem_req) ||
                     ((state == S_DATA) && !data_done)) begin
            // Whole pipe holds while the port is (or is about to be) owned by data access.
            if (state == S_FETCH)
                state_nxt = S_DATA;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (data_done) begin
            state_nxt   = S_FETCH;
            if_id_flush = 1'b1;
            if (ex_branch_taken) begin
                pc_en       = 1'b1;
                pc_sel      = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en = 1'b0;
            end
        end else if (ex_branch_taken) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (luse) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en)
                stall_q <= stall_q + CNT_W'(1);
            if (pc_sel)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             mem_sel, pc_en, pc_sel, if_id_en, if_id_flush;
    logic             id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic             mem_err, err_sticky;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int tests  = 0;
    int failed = 0;

    // Model state: whether the port belongs to data access, how many data cycles have already elapsed,
    // registered error flags and the performance tallies.
    bit          m_valid = 0;
    bit          m_data;
    int          m_wait;
    bit          m_err, m_sticky;
    logic [31:0] m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_sel(mem_sel), .pc_en(pc_en), .pc_sel(pc_sel),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush),
        .mem_err(mem_err), .err_sticky(err_sticky),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluates the intended behaviour for the current inputs, compares, then advances the model one clock.
    task automatic checkOutput();
        bit e_pc_en, e_pc_sel, e_ifid_en, e_ifid_fl, e_idex_en, e_idex_fl, e_exmem_en, e_memwb_fl;
        bit luse, freeze, done, fin;
        luse = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        done = m_data && (mem_ready || (m_wait + 1 >= TMO));
        freeze = (!m_data && mem_req) || (m_data && !done);
        {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = 4'b1111;
        {e_pc_sel, e_ifid_fl, e_idex_fl, e_memwb_fl} = 4'b0000;
        if (rst) begin
            {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = 4'b0000;
        end else if (freeze) begin
            {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = 4'b0000;
            e_memwb_fl = 1;
        end else if (done) begin
            e_ifid_fl = 1;
            e_pc_en   = ex_branch_taken;
            e_pc_sel  = ex_branch_taken;
            e_idex_fl = ex_branch_taken;
        end else if (ex_branch_taken) begin
            e_pc_sel = 1; e_ifid_fl = 1; e_idex_fl = 1;
        end else if (luse) begin
            e_pc_en = 0; e_ifid_en = 0; e_idex_fl = 1;
        end
        check1("pc_en", pc_en, e_pc_en);
        check1("pc_sel", pc_sel, e_pc_sel);
        check1("if_id_en", if_id_en, e_ifid_en);
        check1("if_id_flush", if_id_flush, e_ifid_fl);
        check1("id_ex_en", id_ex_en, e_idex_en);
        check1("id_ex_flush", id_ex_flush, e_idex_fl);
        check1("ex_mem_en", ex_mem_en, e_exmem_en);
        check1("mem_wb_flush", mem_wb_flush, e_memwb_fl);
        if (m_valid) begin
            check1("mem_sel", mem_sel, m_data);
            check1("mem_err", mem_err, m_err);
            check1("err_sticky", err_sticky, m_sticky);
            check1("stall_cnt", stall_cnt, m_stall);
            check1("flush_cnt", flush_cnt, m_flush);
        end
        if (rst) begin
            m_valid = 1; m_data = 0; m_wait = 0; m_err = 0; m_sticky = 0;
            m_stall = 0; m_flush = 0;
        end else begin
            fin    = done && !mem_ready;
            m_err  = fin;
            m_sticky = m_sticky || fin;
`ifdef PIPE_PERF_CNT_EN
            if (!e_pc_en) m_stall = m_stall + 1;
            if (e_pc_sel) m_flush = m_flush + 1;
`endif
            if (!m_data && mem_req) begin
                m_data = 1; m_wait = 0;
            end else if (done) begin
                m_data = 0;
            end else if (m_data) begin
                m_wait++;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input bit ld, input bit br,
                                 input bit mq, input bit my);
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = ld; ex_branch_taken = br; mem_req = mq; mem_ready = my;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        rst = 1; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 3, 0, 0, 0, 0);

        // load-use stall, then the load has moved on
        applyStimulus(0, 5, 9, 5, 1, 0, 0, 0);
        check1("luse_pc_en", pc_en, 0);
        applyStimulus(0, 5, 9, 7, 0, 0, 0, 0);
        check1("after_luse_pc_en", pc_en, 1);

        // x0 exemption and branch beating load-use
        applyStimulus(0, 0, 4, 0, 1, 0, 0, 0);
        check1("x0_pc_en", pc_en, 1);
        applyStimulus(0, 6, 1, 6, 1, 1, 0, 0);
        check1("br_luse_pc_sel", pc_sel, 1);

        // data access completing after three waiting cycles
        applyStimulus(0, 1, 2, 3, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2, 3, 0, 0, 1, 0);
        check1("data_wait_mem_sel", mem_sel, 1);
        applyStimulus(0, 1, 2, 3, 0, 0, 1, 1);
        check1("complete_if_id_flush", if_id_flush, 1);
        applyStimulus(0, 1, 2, 3, 0, 0, 0, 0);
        check1("after_complete_mem_sel", mem_sel, 0);

        // watchdog forced completion
        applyStimulus(0, 1, 2, 3, 0, 0, 1, 0);
        for (int i = 0; i < TMO; i++) applyStimulus(0, 1, 2, 3, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 3, 0, 0, 0, 0);
        check1("tmo_mem_err", mem_err, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2, 3, 0, 0, 0, 0);
        check1("tmo_sticky_held", err_sticky, 1);

        // reset while waiting on data
        applyStimulus(0, 1, 2, 3, 0, 0, 1, 0);
        applyStimulus(0, 1, 2, 3, 0, 0, 1, 0);
        applyStimulus(1, 1, 2, 3, 0, 0, 1, 0);
        applyStimulus(0, 1, 2, 3, 0, 0, 0, 0);
        check1("rst_data_mem_sel", mem_sel, 0);
        check1("rst_data_sticky", err_sticky, 0);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            applyStimulus($urandom_range(0, 63) == 0,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
